// File: rtl/lcd_keyscan_arbiter.sv
// Shares the 8-bit LCD data / keyboard row bus: pauses the LCD, scans one keyboard column per
// scan period, and reports per-column key state changes on a valid/ready event port.
module lcd_keyscan_arbiter #(
  parameter int unsigned SCAN_PERIOD = 1000,
  parameter int unsigned LCD_DRAIN   = 64,
  parameter int unsigned SETTLE      = 500,
  parameter int unsigned NUM_COLS    = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_en,
  input  logic                lcd_busy,
  output logic                lcd_run,
  output logic                bus_oe,
  output logic [NUM_COLS-1:0] col_driver,
  input  logic [7:0]          key_row,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [3:0]          evt_col,
  output logic [7:0]          evt_rows,
  output logic [7:0]          evt_changed
);

  localparam int unsigned CntMax1 = (SCAN_PERIOD > LCD_DRAIN) ? SCAN_PERIOD : LCD_DRAIN;
  localparam int unsigned CntMax  = (CntMax1 > SETTLE) ? CntMax1 : SETTLE;
  localparam int unsigned CntW    = $clog2(CntMax);

  localparam logic [CntW-1:0] PeriodLast = CntW'(SCAN_PERIOD - 1);
  localparam logic [CntW-1:0] DrainLast  = CntW'(LCD_DRAIN - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
  localparam logic [3:0]      ColLast    = 4'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    StRun,
    StStop,
    StDrive,
    StSettle,
    StSample,
    StResume
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          col_q, col_d;
  logic [7:0]          keys_q [NUM_COLS];
  logic [7:0]          cur_keys;
  logic [7:0]          pressed;
  logic                slot_free;
  logic                upd;
  logic                lcd_run_d, bus_oe_d, evt_valid_d;
  logic [NUM_COLS-1:0] col_driver_d;
  logic [NUM_COLS-1:0] col_onehot;
  logic [3:0]          evt_col_d;
  logic [7:0]          evt_rows_d, evt_changed_d;

  always_comb begin
    cur_keys = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col_q == 4'(i)) cur_keys = keys_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    col_d         = col_q;
    upd           = 1'b0;
    pressed       = ~key_row;
    slot_free     = !evt_valid || evt_ready;
    evt_valid_d   = evt_valid && !evt_ready;
    evt_col_d     = evt_col;
    evt_rows_d    = evt_rows;
    evt_changed_d = evt_changed;

    unique case (state_q)
      StRun: begin
        if (!scan_en) begin
          cnt_d = '0;
        end else if (cnt_q == PeriodLast) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        // The drain timeout forces the bus over even if the LCD never reports idle.
        if (!lcd_busy || cnt_q == DrainLast) begin
          cnt_d   = '0;
          state_d = StDrive;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrive: begin
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        state_d = StResume;
        // A change seen while the slot is busy is left unabsorbed and re-detected next scan.
        if (pressed != cur_keys && slot_free) begin
          upd           = 1'b1;
          evt_valid_d   = 1'b1;
          evt_col_d     = col_q;
          evt_rows_d    = pressed;
          evt_changed_d = pressed ^ cur_keys;
        end
      end
      StResume: begin
        cnt_d   = '0;
        state_d = StRun;
        col_d   = (col_q == ColLast) ? 4'd0 : col_q + 4'd1;
      end
      default: begin
        cnt_d   = '0;
        state_d = StRun;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    lcd_run_d    = 1'b1;
    bus_oe_d     = 1'b1;
    col_driver_d = '1;
    col_onehot   = NUM_COLS'(1) << col_d;
    case (state_d)
      StStop: lcd_run_d = 1'b0;
      StDrive, StSettle, StSample: begin
        lcd_run_d    = 1'b0;
        bus_oe_d     = 1'b0;
        col_driver_d = ~col_onehot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      col_q       <= '0;
      lcd_run     <= 1'b1;
      bus_oe      <= 1'b1;
      col_driver  <= '1;
      evt_valid   <= 1'b0;
      evt_col     <= '0;
      evt_rows    <= '0;
      evt_changed <= '0;
      for (int i = 0; i < NUM_COLS; i++) keys_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      lcd_run     <= lcd_run_d;
      bus_oe      <= bus_oe_d;
      col_driver  <= col_driver_d;
      evt_valid   <= evt_valid_d;
      evt_col     <= evt_col_d;
      evt_rows    <= evt_rows_d;
      evt_changed <= evt_changed_d;
      for (int i = 0; i < NUM_COLS; i++) begin
        if (upd && col_q == 4'(i)) keys_q[i] <= pressed;
      end
    end
  end

endmodule

// File: tb/tb_lcd_keyscan_arbiter.sv
// Directed bench for lcd_keyscan_arbiter: a keyboard matrix model feeds key_row, expected events
// are queued by the stimulus and popped by a monitor on each accepted transfer.
module tb_lcd_keyscan_arbiter;

  localparam int unsigned NC     = 9;
  localparam int unsigned Period = 10;
  localparam int unsigned Settle = 3;
  localparam int unsigned Drain  = 64;

  typedef struct packed {
    logic [3:0] col;
    logic [7:0] rows;
    logic [7:0] chg;
  } evt_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          scan_en = 1'b1;
  logic          lcd_busy = 1'b0;
  logic          evt_ready = 1'b1;
  logic          lcd_run, bus_oe, evt_valid;
  logic [NC-1:0] col_driver;
  logic [7:0]    key_row, evt_rows, evt_changed;
  logic [3:0]    evt_col;
  logic [7:0]    keys [NC];

  evt_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lcd_keyscan_arbiter #(
    .SCAN_PERIOD(Period),
    .LCD_DRAIN  (Drain),
    .SETTLE     (Settle),
    .NUM_COLS   (NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .lcd_busy   (lcd_busy),
    .lcd_run    (lcd_run),
    .bus_oe     (bus_oe),
    .col_driver (col_driver),
    .key_row    (key_row),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_col    (evt_col),
    .evt_rows   (evt_rows),
    .evt_changed(evt_changed)
  );

  // Pressed keys pull their row low only while their column is driven low.
  always_comb begin
    key_row = 8'hFF;
    for (int c = 0; c < NC; c++) begin
      if (!col_driver[c]) key_row = key_row & ~keys[c];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: safety invariant, hold stability, and scoreboard pops on each transfer.
  logic prev_hold = 1'b0;
  evt_t prev_evt, cur_evt, exp_evt;
  always @(negedge clk) begin
    cur_evt = {evt_col, evt_rows, evt_changed};
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (col_driver != '1) check("invariant", {30'd0, bus_oe, lcd_run}, 32'd0);
      if (prev_hold) check("evt_stable", {11'd0, evt_valid, cur_evt}, {11'd0, 1'b1, prev_evt});
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_evt: got %h, expected no event", cur_evt);
        end else begin
          exp_evt = exp_q.pop_front();
          check("evt", 32'(cur_evt), 32'(exp_evt));
        end
      end
      prev_hold = evt_valid && !evt_ready;
      prev_evt  = cur_evt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] col, input logic [7:0] rows, input logic [7:0] chg);
    exp_q.push_back({col, rows, chg});
  endtask

  task automatic wait_low(input int budget, output int n);
    n = 0;
    while (col_driver == '1 && n < budget) begin
      tick();
      n++;
    end
    if (col_driver == '1) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_low: got no column drive, expected one within %0d cycles", budget);
      n = -1;
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!evt_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", {31'd0, evt_valid}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Waits for the next STOP entry, then counts STOP cycles; lcd_busy drops on cycle drop_at.
  task automatic measure_stop(input int drop_at, output int n);
    int b = 0;
    n = 0;
    while (!lcd_run && b < 300) begin tick(); b++; end
    while (lcd_run && b < 300) begin tick(); b++; end
    while (!lcd_run && bus_oe && n < 200) begin
      n++;
      if (n == drop_at) lcd_busy = 1'b0;
      tick();
    end
  endtask

  initial begin
    int            n;
    int            bad;
    logic [NC-1:0] one;
    logic [NC-1:0] exp_cd;
    one = NC'(1);
    for (int c = 0; c < NC; c++) keys[c] = 8'h00;

    repeat (3) tick();
    check("rst_lcd_run", {31'd0, lcd_run}, 32'd1);
    check("rst_bus_oe", {31'd0, bus_oe}, 32'd1);
    check("rst_col_driver", 32'(col_driver), 32'h1FF);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_fields", 32'({evt_col, evt_rows, evt_changed}), 32'd0);
    reset = 1'b0;

    // Column walk with no keys: 1FE, 1FD, ..., 0FF, 1FE, each low for DRIVE+SETTLE+SAMPLE.
    for (int k = 0; k < 10; k++) begin
      wait_low(60, n);
      if (k == 0) check("first_scan_latency", 32'(n), 32'(Period + 1));
      exp_cd = ~(one << (k % NC));
      check("col_seq", 32'(col_driver), 32'(exp_cd));
      n = 0;
      while (col_driver != '1 && n < 20) begin
        n++;
        tick();
      end
      check("col_low_len", 32'(n), 32'(Settle + 2));
    end

    // Single key press and release on column 2, row 2.
    keys[2] = 8'h04;
    push(4'd2, 8'h04, 8'h04);
    wait_drain(400);
    keys[2] = 8'h00;
    push(4'd2, 8'h00, 8'h04);
    wait_drain(400);

    // Back-pressure: col-1 event held, col-3 change deferred until the slot frees.
    evt_ready = 1'b0;
    keys[1] = 8'h01;
    push(4'd1, 8'h01, 8'h01);
    wait_valid(400);
    check("bp_col", 32'(evt_col), 32'd1);
    keys[3] = 8'h20;
    push(4'd3, 8'h20, 8'h20);
    repeat (400) tick();
    check("bp_hold_valid", {31'd0, evt_valid}, 32'd1);
    check("bp_hold_col", 32'(evt_col), 32'd1);
    check("bp_hold_rows", 32'(evt_rows), 32'h01);
    evt_ready = 1'b1;
    wait_drain(400);
    keys[1] = 8'h00;
    push(4'd1, 8'h00, 8'h01);
    wait_drain(400);
    keys[3] = 8'h00;
    push(4'd3, 8'h00, 8'h20);
    wait_drain(400);

    // LCD busy for 20 cycles after STOP entry, then stuck busy.
    lcd_busy = 1'b1;
    measure_stop(21, n);
    check("stop_len_busy20", 32'(n), 32'd21);
    check("drive_after_busy", {31'd0, bus_oe}, 32'd0);
    lcd_busy = 1'b1;
    measure_stop(0, n);
    check("stop_len_timeout", 32'(n), 32'(Drain));
    check("drive_after_timeout", {31'd0, bus_oe}, 32'd0);
    lcd_busy = 1'b0;

    // scan_en low: current scan finishes, then the LCD keeps the bus.
    scan_en = 1'b0;
    repeat (40) tick();
    bad = 0;
    repeat (200) begin
      if (col_driver != '1 || !lcd_run || !bus_oe) bad++;
      tick();
    end
    check("scan_dis_idle", 32'(bad), 32'd0);
    scan_en = 1'b1;

    // Reset during SETTLE with an event pending: bus released at once, event dropped.
    evt_ready = 1'b0;
    keys[0] = 8'h01;
    wait_valid(400);
    keys[0] = 8'h00;
    wait_low(200, n);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midscan_rst_col", 32'(col_driver), 32'h1FF);
    check("midscan_rst_oe", {31'd0, bus_oe}, 32'd1);
    check("midscan_rst_run", {31'd0, lcd_run}, 32'd1);
    check("midscan_rst_valid", {31'd0, evt_valid}, 32'd0);
    reset = 1'b0;
    evt_ready = 1'b1;
    wait_low(60, n);
    check("post_rst_latency", 32'(n), 32'(Period + 1));
    check("post_rst_col0", 32'(col_driver), 32'h1FE);

    repeat (200) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
